// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: BTB counter encodings, the BIOS select bit
// and the NOP that decode substitutes on bubbles.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  localparam int          BIOS_SEL_BIT = 30;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // 2-bit saturating counter step.
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : ctr_e'(c + 2'd1);
    else       return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Pipeline-facing signals of the fetch stage, grouped for the top-level port list.
interface fetch_stage_if;
  // No valid/ready pair: id_valid qualifies id_pc every cycle, id_stall is the only backpressure.
  logic        id_stall;
  logic        wb_flush;
  logic [31:0] wb_redirect;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_br_inst;
  logic        ex_br_taken;
  logic        ex_is_uncond;
  logic [31:0] fetch_addr;
  logic        fetch_bios_en;
  logic [31:0] id_pc;
  logic        id_target_taken;
  logic        id_valid;

  modport master (
    output id_stall, wb_flush, wb_redirect, ex_pc, ex_target,
           ex_br_inst, ex_br_taken, ex_is_uncond,
    input  fetch_addr, fetch_bios_en, id_pc, id_target_taken, id_valid
  );

  modport slave (
    input  id_stall, wb_flush, wb_redirect, ex_pc, ex_target,
           ex_br_inst, ex_br_taken, ex_is_uncond,
    output fetch_addr, fetch_bios_en, id_pc, id_target_taken, id_valid
  );
endinterface

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer in flops: combinational lookup, one write port.
module fetch_stage_btb
  import fetch_stage_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic        upd_uncond,
  input  logic        upd_taken,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  logic             wr_hit, wr_alloc, wr_train, wr_target;
  logic             unused_pc_bits;

  assign lk_idx         = lookup_pc[IDX_W+1:2];
  assign lk_tag         = lookup_pc[31:IDX_W+2];
  assign wr_idx         = upd_pc[IDX_W+1:2];
  assign wr_tag         = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lookup_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = lookup_hit && (ctr_q[lk_idx] >= CTR_WT);
  assign lookup_target = target_q[lk_idx];

  always_comb begin
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_alloc  = upd_en && (upd_uncond || (!wr_hit && upd_taken));
    wr_train  = upd_en && !upd_uncond && wr_hit;
    wr_target = wr_alloc || (wr_train && upd_taken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (wr_alloc) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= upd_uncond ? CTR_ST : CTR_WT;
    end else if (wr_train) begin
      ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], upd_taken);
    end
  end

  // Tag/target storage is deliberately not reset; valid_q guards it.
  always_ff @(posedge clk) begin
    if (wr_alloc)  tag_q[wr_idx]    <= wr_tag;
    if (wr_target) target_q[wr_idx] <= upd_target;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and BTB-based prediction.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  logic [31:0] pc_q, next_pc, btb_target;
  logic        valid_q, pred_q, pred, upd_en;
  logic        btb_hit_unused;

  assign upd_en = (bus.ex_br_inst || bus.ex_is_uncond) && !bus.id_stall && !bus.wb_flush;

  fetch_stage_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .lookup_hit    (btb_hit_unused),
    .lookup_taken  (pred),
    .lookup_target (btb_target),
    .upd_en        (upd_en),
    .upd_uncond    (bus.ex_is_uncond),
    .upd_taken     (bus.ex_br_taken),
    .upd_pc        (bus.ex_pc),
    .upd_target    (bus.ex_target)
  );

  // Flush beats stall beats prediction; reset pins the address to the first fetch.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (!rst)              next_pc = RESET_PC;
    else if (bus.wb_flush) next_pc = bus.wb_redirect;
    else if (bus.id_stall) next_pc = pc_q;
    else if (pred)         next_pc = btb_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC - 32'd4;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      pc_q <= next_pc;
      if (bus.wb_flush) begin
        valid_q <= 1'b0;
        pred_q  <= 1'b0;
      end else if (!bus.id_stall) begin
        valid_q <= 1'b1;
        pred_q  <= pred;
      end
    end
  end

  assign bus.fetch_addr      = next_pc;
  assign bus.fetch_bios_en   = next_pc[BIOS_SEL_BIT];
  assign bus.id_pc           = pc_q;
  assign bus.id_valid        = valid_q;
  assign bus.id_target_taken = pred_q;

endmodule
